mem_copy_engine: RTL and testbench

Bus-initiator block that drives the data memory's single port (address, write strobe, write data, combinational read data) to move or fill blocks of words without CPU involvement. It sits beside the datapath on the data memory port through the team's port mux and is commanded by a start pulse with source, destination and length. It performs memmove-safe copies (direction chosen for overlap) and constant fills, then reports done or error.

---
 rtl/mem_copy_engine_pkg.sv | 19 +
 rtl/mem_copy_addr_gen.sv | 48 ++++
 rtl/mem_copy_engine.sv | 154 +++++++++++++++
 tb/tb_mem_copy_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared constants and FSM state type for the copy engine
// Purpose: memory geometry defaults shared with the data memory, plus the
// engine's state encoding. No ports.
package mem_copy_engine_pkg;

  localparam int MEM_ADDR_W      = 16;
  localparam int MEM_DATA_W      = 16;
  localparam int MEM_DEPTH_WORDS = 32;
  localparam int MEM_LEN_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// rtl/mem_copy_addr_gen.sv - word offset and remaining-count tracker for the copy engine
// Purpose: holds the current word offset (stepping up or down) and the number
// of words still to move.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       initialise from length_i / descend_i
//   descend_i    1 = start at length-1 and step down
//   length_i     word count of the command
//   step_i       one word has been written; advance
//   offset_o     current word offset from src/dst base
//   last_o       current word is the final one
module mem_copy_addr_gen #(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             descend_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic             step_i,
  output logic [LEN_W-1:0] offset_o,
  output logic             last_o
);

  logic [LEN_W-1:0] offset_q;
  logic [LEN_W-1:0] remain_q;
  logic             descend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q  <= '0;
      remain_q  <= '0;
      descend_q <= 1'b0;
    end else if (load_i) begin
      // length 0 never reaches a step, so the wrapped length-1 is harmless
      offset_q  <= descend_i ? (length_i - LEN_W'(1)) : '0;
      remain_q  <= length_i;
      descend_q <= descend_i;
    end else if (step_i) begin
      remain_q <= remain_q - LEN_W'(1);
      offset_q <= descend_q ? (offset_q - LEN_W'(1)) : (offset_q + LEN_W'(1));
    end
  end

  assign offset_o = offset_q;
  assign last_o   = (remain_q == LEN_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - memmove-safe block copy / fill initiator on the data memory port
// Purpose: accepts a command (copy or fill, src, dst, length), bounds-checks
// it, then moves words one read/write pair at a time (or writes the fill
// constant) and reports done or error.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, fill, src_addr,
//   dst_addr, length, fill_value   command, sampled in IDLE only
//   abort                          cancel the operation in progress
//   address, MemWrite, writeData   memory port drive
//   readData                       combinational memory read data
//   busy, done, error              status
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MEM_DEPTH = MEM_DEPTH_WORDS,
  parameter int LEN_W     = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic [ADDR_W-1:0] address,
  output logic              MemWrite,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q;
  logic              fill_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fval_q;
  logic [DATA_W-1:0] hold_q;
  logic [ADDR_W-1:0] last_addr_q;

  logic [LEN_W-1:0]  offset;
  logic              last_word;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic              bad_range;
  logic              descend;
  logic              step;

  // One extra bit so base+length never wraps past the top of the address space
  assign src_end   = {1'b0, src_q} + (ADDR_W+1)'(len_q);
  assign dst_end   = {1'b0, dst_q} + (ADDR_W+1)'(len_q);
  assign bad_range = (!fill_q && (src_end > (ADDR_W+1)'(MEM_DEPTH))) ||
                     (dst_end > (ADDR_W+1)'(MEM_DEPTH));
  // Destination starts inside the source window: copy from the top down so
  // source words are read before they are overwritten
  assign descend   = !fill_q && (dst_q > src_q) && ({1'b0, dst_q} < src_end);
  assign step      = (state_q == ST_WRITE) && !abort;

  mem_copy_addr_gen #(
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_CHECK),
    .descend_i (descend),
    .length_i  (len_q),
    .step_i    (step),
    .offset_o  (offset),
    .last_o    (last_word)
  );

  always_comb begin
    address = last_addr_q;
    if (state_q == ST_READ) begin
      address = src_q + ADDR_W'(offset);
    end else if (state_q == ST_WRITE) begin
      address = dst_q + ADDR_W'(offset);
    end
  end

  // abort suppresses the strobe in the same cycle, so a cancelled write never lands
  assign MemWrite  = (state_q == ST_WRITE) && !abort;
  assign writeData = (state_q == ST_WRITE) ? (fill_q ? fval_q : hold_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign error     = (state_q == ST_CHECK) && bad_range && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fill_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      fval_q      <= '0;
      hold_q      <= '0;
      last_addr_q <= '0;
    end else begin
      last_addr_q <= address;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fill_q  <= fill;
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= length;
            fval_q  <= fill_value;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort || bad_range) begin
            state_q <= ST_IDLE;
          end else if (len_q == '0) begin
            state_q <= ST_FINISH;
          end else begin
            state_q <= fill_q ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            hold_q  <= readData;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (last_word) begin
            state_q <= ST_FINISH;
          end else begin
            state_q <= fill_q ? ST_WRITE : ST_READ;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, fill, abort;
  logic [15:0] src_addr, dst_addr, fill_value;
  logic [5:0]  length;
  logic [15:0] address, writeData, readData;
  logic        MemWrite, busy, done, error;

  logic [15:0] mem    [0:31];
  logic [15:0] wr_log [0:63];
  int          wr_cnt, done_cnt, err_cnt;
  logic        bd_we, bd_clr;
  logic [4:0]  bd_addr;
  logic [15:0] bd_data;

  int checks   = 0;
  int failures = 0;
  int done_cyc, err_cyc, idle_cyc;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fill       (fill),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .address    (address),
    .MemWrite   (MemWrite),
    .writeData  (writeData),
    .readData   (readData),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  assign readData = (address < 16'd32) ? mem[address[4:0]] : 16'h0000;

  // Memory model plus event log; backdoor writes share this block
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
      wr_cnt   <= 0;
      done_cnt <= 0;
      err_cnt  <= 0;
    end else begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (MemWrite) begin
        if (address < 16'd32) mem[address[4:0]] <= writeData;
        if (wr_cnt < 64) wr_log[wr_cnt[5:0]] <= address;
        wr_cnt <= wr_cnt + 1;
      end
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    bd_clr = 1'b1;
    @(negedge clk);
    bd_clr = 1'b0;
  endtask

  task automatic bd_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue a command; report the cycle (counted from the sampling edge) in
  // which done / error was first seen and the first cycle busy was low
  task automatic run_cmd(input logic f, input logic [15:0] s, input logic [15:0] d,
                         input logic [5:0] l, input logic [15:0] fv,
                         output int dc, output int ec, output int ic);
    @(negedge clk);
    fill = f; src_addr = s; dst_addr = d; length = l; fill_value = fv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc = -1; ec = -1; ic = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done && dc < 0) dc = k;
      if (error && ec < 0) ec = k;
      if (!busy) begin
        ic = k;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fill = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    bd_we = 1'b0; bd_clr = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_memwrite", 32'(MemWrite), 32'h0);
    chk("rst_writedata", 32'(writeData), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending copy 0..3 -> 8..11
    clear_mem();
    for (int i = 0; i < 4; i++) bd_write(5'(i), 16'(i + 1));
    run_cmd(1'b0, 16'd0, 16'd8, 6'd4, 16'h0, done_cyc, err_cyc, idle_cyc);
    chk("asc_done_cycle", 32'(done_cyc), 32'd10);
    chk("asc_idle_cycle", 32'(idle_cyc), 32'd11);
    chk("asc_no_error", 32'(err_cyc), 32'hffffffff);
    for (int i = 0; i < 4; i++) chk($sformatf("asc_mem%0d", 8 + i), 32'(mem[8 + i]), 32'(i + 1));
    chk("asc_wr_cnt", 32'(wr_cnt), 32'd4);

    // Overlapping copy 0..3 -> 2..5, must run top-down
    clear_mem();
    for (int i = 0; i < 4; i++) bd_write(5'(i), 16'(i + 1));
    run_cmd(1'b0, 16'd0, 16'd2, 6'd4, 16'h0, done_cyc, err_cyc, idle_cyc);
    chk("ovl_done_cycle", 32'(done_cyc), 32'd10);
    for (int i = 0; i < 4; i++) chk($sformatf("ovl_mem%0d", 2 + i), 32'(mem[2 + i]), 32'(i + 1));
    chk("ovl_mem0", 32'(mem[0]), 32'd1);
    chk("ovl_mem1", 32'(mem[1]), 32'd2);
    chk("ovl_wr_cnt", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovl_order%0d", i), 32'(wr_log[i]), 32'(5 - i));

    // Fill 20..24 with BEEF, neighbours untouched
    clear_mem();
    bd_write(5'd19, 16'h1111);
    bd_write(5'd25, 16'h2222);
    run_cmd(1'b1, 16'd0, 16'd20, 6'd5, 16'hBEEF, done_cyc, err_cyc, idle_cyc);
    chk("fill_done_cycle", 32'(done_cyc), 32'd7);
    for (int i = 20; i < 25; i++) chk($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'hBEEF);
    chk("fill_mem19", 32'(mem[19]), 32'h1111);
    chk("fill_mem25", 32'(mem[25]), 32'h2222);

    // Fill ending exactly at MEM_DEPTH is legal; src is ignored for fills
    clear_mem();
    run_cmd(1'b1, 16'd30, 16'd28, 6'd4, 16'h5A5A, done_cyc, err_cyc, idle_cyc);
    chk("edge_done_cycle", 32'(done_cyc), 32'd6);
    chk("edge_no_error", 32'(err_cyc), 32'hffffffff);
    chk("edge_mem31", 32'(mem[31]), 32'h5A5A);

    // Destination out of range
    clear_mem();
    run_cmd(1'b0, 16'd0, 16'd30, 6'd4, 16'h0, done_cyc, err_cyc, idle_cyc);
    chk("bnd_dst_err_cycle", 32'(err_cyc), 32'd1);
    chk("bnd_dst_idle_cycle", 32'(idle_cyc), 32'd2);
    @(negedge clk);
    chk("bnd_dst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("bnd_dst_done_cnt", 32'(done_cnt), 32'd0);
    chk("bnd_dst_err_cnt", 32'(err_cnt), 32'd1);

    // Source out of range on a copy
    clear_mem();
    run_cmd(1'b0, 16'd30, 16'd0, 6'd4, 16'h0, done_cyc, err_cyc, idle_cyc);
    chk("bnd_src_err_cycle", 32'(err_cyc), 32'd1);
    chk("bnd_src_wr_cnt", 32'(wr_cnt), 32'd0);

    // Zero length
    clear_mem();
    run_cmd(1'b0, 16'd0, 16'd4, 6'd0, 16'h0, done_cyc, err_cyc, idle_cyc);
    chk("len0_done_cycle", 32'(done_cyc), 32'd2);
    chk("len0_wr_cnt", 32'(wr_cnt), 32'd0);

    // Abort during the 3rd write of an 8-word copy; a second start mid-run is ignored
    clear_mem();
    for (int i = 0; i < 8; i++) bd_write(5'(i), 16'(10 + i));
    @(negedge clk);
    fill = 1'b0; src_addr = 16'd0; dst_addr = 16'd16; length = 6'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fill = 1'b1; dst_addr = 16'd0; length = 6'd1; fill_value = 16'hDEAD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    #1;
    chk("abort_memwrite_forced", 32'(MemWrite), 32'h0);
    chk("abort_busy_during", 32'(busy), 32'h1);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy_after", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    chk("abort_mem16", 32'(mem[16]), 32'd10);
    chk("abort_mem17", 32'(mem[17]), 32'd11);
    chk("abort_mem18", 32'(mem[18]), 32'd0);
    chk("abort_mem0_kept", 32'(mem[0]), 32'd10);

    // Reset in the second write of a copy
    clear_mem();
    for (int i = 0; i < 4; i++) bd_write(5'(i), 16'(i + 1));
    @(negedge clk);
    fill = 1'b0; src_addr = 16'd0; dst_addr = 16'd8; length = 6'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_memwrite_before", 32'(MemWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_memwrite", 32'(MemWrite), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    chk("rstmid_error", 32'(error), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("rstmid_mem8", 32'(mem[8]), 32'd1);
    chk("rstmid_mem9", 32'(mem[9]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
